lpf3x3_mc: RTL and testbench



---
 rtl/lpf3x3_pkg.sv | 7 +
 rtl/lpf3x3_ch_kernel.sv | 22 ++
 rtl/lpf3x3_mc.sv | 137 +++++++++++++
 tb/tb_lpf3x3_mc.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/lpf3x3_pkg.sv
// lpf3x3_pkg: shared state encoding and kernel constants for the 3x3 filter
package lpf3x3_pkg;
   typedef enum logic [2:0] {INIT, RUN, FLUSH, DRAIN, DONE} state_t;
   localparam logic [8:0][2:0] KW = {3'd1, 3'd2, 3'd1, 3'd2, 3'd4, 3'd2, 3'd1, 3'd2, 3'd1};
   localparam int RND = 8;
   localparam int SH  = 4;
endpackage

// File: rtl/lpf3x3_ch_kernel.sv
// lpf3x3_ch_kernel: one channel, 9-tap weighted sum, rounding, optional unsharp clamp
module lpf3x3_ch_kernel import lpf3x3_pkg::*; #(
   parameter int PB = 8
) (
   input  logic [9*PB-1:0] i_tap,
   input  logic            i_sharpen,
   output logic [PB-1:0]   o_px
);
   logic [PB+3:0] w_sum;
   logic [PB-1:0] w_lpf;
   logic [PB+1:0] w_sh;
   // weighted sum of the window; tap 4 is the centre
   always_comb begin
      w_sum = '0;
      for (int k = 0; k < 9; k++)
         w_sum = w_sum + (PB+4)'(i_tap[k*PB +: PB]) * (PB+4)'(KW[k]);
   end
   assign w_lpf = PB'((w_sum + (PB+4)'(RND)) >> SH);
   // 2*centre - lpf in two's complement; bit PB+1 is the sign, bit PB the overflow
   assign w_sh  = {1'b0, i_tap[4*PB +: PB], 1'b0} - {2'b0, w_lpf};
   assign o_px  = !i_sharpen ? w_lpf : w_sh[PB+1] ? '0 : w_sh[PB] ? '1 : w_sh[PB-1:0];
endmodule

// File: rtl/lpf3x3_mc.sv
// lpf3x3_mc: multi-channel 3x3 low-pass filter, zero-pad/replicate edges, bypass; LPF3X3_MC_SHARPEN_EN adds cfg_sharpen
module lpf3x3_mc import lpf3x3_pkg::*; #(
   parameter int XB = 10,
   parameter int YB = 10,
   parameter int PB = 8,
   parameter int CH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XB-1:0]    cfg_width,
   input  logic [YB-1:0]    cfg_height,
   input  logic             cfg_edge,
   input  logic             cfg_bypass,
`ifdef LPF3X3_MC_SHARPEN_EN
   input  logic             cfg_sharpen,
`endif
   output logic             px_in_ready,
   input  logic             px_in_valid,
   input  logic [CH*PB-1:0] px_in_data,
   input  logic             px_out_ready,
   output logic             px_out_valid,
   output logic             px_out_last_x,
   output logic             px_out_last_y,
   output logic [CH*PB-1:0] px_out_data,
   output logic             done
);
   localparam int DW = CH*PB;
   logic [DW-1:0] r_lb1 [2**XB];
   logic [DW-1:0] r_lb2 [2**XB];
   logic [DW-1:0] r_rd1, r_rd2, w_in, w_out, w_nxt;
   logic [XB-1:0] r_cw, r_x, r_ox, w_xn, w_ra;
   logic [YB-1:0] r_ch, r_y, r_oy;
   logic [XB:0] r_fl, r_n, r_fc;
   logic r_ce, r_cb, w_sh, w_free, w_beat, w_emit, w_top, w_bot, w_lft, w_rgt;
   logic [2:0][2:0][DW-1:0] r_w, w_w, w_r, w_t;
   state_t r_st;
   // configuration is sampled continuously while in reset
   always_ff @(posedge clk)
      if (rst) begin
         r_cw <= cfg_width;
         r_ch <= cfg_height;
         r_ce <= cfg_edge;
         r_cb <= cfg_bypass;
      end
`ifdef LPF3X3_MC_SHARPEN_EN
   logic r_cs;
   // sharpen select, sampled alongside the other configuration
   always_ff @(posedge clk)
      if (rst) r_cs <= cfg_sharpen;
   assign w_sh = r_cs & ~r_cb;
`else
   assign w_sh = 1'b0;
`endif
   assign w_free      = !px_out_valid | px_out_ready;
   assign px_in_ready = (r_st == RUN) & w_free;
   assign w_beat      = (px_in_valid & px_in_ready | r_st == FLUSH) & w_free;
   assign w_emit      = r_n == r_fl;
   assign w_xn        = r_x == r_cw ? '0 : r_x + 1'b1;
   assign w_ra        = w_beat ? w_xn : r_x;
   assign w_in        = r_st == RUN ? px_in_data : '0;
   // window after this beat: shift left, new right column is {input, row-1, row-2}
   assign w_w   = {{w_in, r_rd1, r_rd2}, r_w[2], r_w[1]};
   assign w_top = r_oy == '0;
   assign w_bot = r_oy == r_ch;
   assign w_lft = r_ox == '0;
   assign w_rgt = r_ox == r_cw;
   // out-of-image taps chosen by centre position only, so stale RAM rows never leak through
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         w_r[c][0] = w_top ? (r_ce ? w_w[c][1] : '0) : w_w[c][0];
         w_r[c][1] = w_w[c][1];
         w_r[c][2] = w_bot ? (r_ce ? w_w[c][1] : '0) : w_w[c][2];
      end
      w_t[0] = w_lft ? (r_ce ? w_r[1] : '0) : w_r[0];
      w_t[1] = w_r[1];
      w_t[2] = w_rgt ? (r_ce ? w_r[1] : '0) : w_r[2];
   end
   for (genvar g = 0; g < CH; g++) begin : g_ch
      logic [9*PB-1:0] w_tap;
      for (genvar r = 0; r < 3; r++) begin : g_r
         for (genvar c = 0; c < 3; c++) begin : g_c
            assign w_tap[(3*r+c)*PB +: PB] = w_t[c][r][g*PB +: PB];
         end
      end
      lpf3x3_ch_kernel #(.PB(PB)) u_k (.i_tap(w_tap), .i_sharpen(w_sh), .o_px(w_out[g*PB +: PB]));
   end
   assign w_nxt = r_cb ? w_w[1][1] : w_out;
   // line buffers with 1-cycle read; same-address write forwards (only happens at width 0)
   always_ff @(posedge clk) begin
      if (w_beat) begin
         r_lb1[r_x] <= w_in;
         r_lb2[r_x] <= r_rd1;
      end
      r_rd1 <= (w_beat && w_ra == r_x) ? w_in : r_lb1[w_ra];
      r_rd2 <= (w_beat && w_ra == r_x) ? r_rd1 : r_lb2[w_ra];
   end
   // frame FSM, pipeline advance and registered output slot
   always_ff @(posedge clk)
      if (rst) begin
         r_st          <= INIT;
         r_x           <= '0;
         r_y           <= '0;
         r_ox          <= '0;
         r_oy          <= '0;
         r_n           <= '0;
         r_fc          <= '0;
         r_fl          <= '0;
         px_out_valid  <= 1'b0;
         px_out_last_x <= 1'b0;
         px_out_last_y <= 1'b0;
         px_out_data   <= '0;
         done          <= 1'b0;
      end else begin
         case (r_st)
            INIT:    begin r_fl <= (XB+1)'(r_cw) + (XB+1)'(2); r_st <= RUN; end
            RUN:     if (w_beat && r_x == r_cw && r_y == r_ch) r_st <= FLUSH;
            FLUSH:   if (w_beat && r_fc == r_fl - 1'b1) r_st <= DRAIN;
            DRAIN:   if (px_out_valid && px_out_ready) begin r_st <= DONE; done <= 1'b1; end
            default: ;
         endcase
         if (w_beat) begin
            r_w          <= w_w;
            r_x          <= w_xn;
            r_y          <= r_x == r_cw ? r_y + 1'b1 : r_y;
            r_fc         <= r_st == FLUSH ? r_fc + 1'b1 : r_fc;
            r_n          <= w_emit ? r_n : r_n + 1'b1;
            px_out_valid <= w_emit;
            if (w_emit) begin
               px_out_data   <= w_nxt;
               px_out_last_x <= w_rgt;
               px_out_last_y <= w_bot;
               r_ox          <= w_rgt ? '0 : r_ox + 1'b1;
               r_oy          <= w_rgt ? r_oy + 1'b1 : r_oy;
            end
         end else if (px_out_ready) px_out_valid <= 1'b0;
      end
endmodule

// File: tb/tb_lpf3x3_mc.sv
// tb_lpf3x3_mc: directed table vectors plus random-stall frames for lpf3x3_mc
module tb_lpf3x3_mc;
   logic clk = 0, rst = 1;
   logic [9:0] cfg_width = 0, cfg_height = 0;
   logic cfg_edge = 0, cfg_bypass = 0;
`ifdef LPF3X3_MC_SHARPEN_EN
   logic cfg_sharpen = 0;
`endif
   logic px_in_ready, px_in_valid = 0, px_out_ready = 0;
   logic px_out_valid, px_out_last_x, px_out_last_y, done;
   logic [23:0] px_in_data = 0, px_out_data;
   int n_chk = 0, n_pass = 0;
   logic [23:0] img [64];
   logic [23:0] exp_a [64];
   typedef struct {
      int w; int h; bit e; bit b; int v;
      int e_mid; int e_x; int e_y; int e_c; int e_p;
   } vec_t;
   vec_t tv [5];

   always #5 clk = ~clk;

   lpf3x3_mc dut (
      .clk(clk), .rst(rst), .cfg_width(cfg_width), .cfg_height(cfg_height),
      .cfg_edge(cfg_edge), .cfg_bypass(cfg_bypass),
`ifdef LPF3X3_MC_SHARPEN_EN
      .cfg_sharpen(cfg_sharpen),
`endif
      .px_in_ready(px_in_ready), .px_in_valid(px_in_valid), .px_in_data(px_in_data),
      .px_out_ready(px_out_ready), .px_out_valid(px_out_valid),
      .px_out_last_x(px_out_last_x), .px_out_last_y(px_out_last_y),
      .px_out_data(px_out_data), .done(done)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %0d want %0d", nm, act, want);
   endtask

   function automatic logic [7:0] gold(int x, int y, int c, int w, int h, bit e);
      int sum, l, xx, yy, wt;
      logic [23:0] p;
      sum = 0;
      for (int dy = -1; dy <= 1; dy++)
         for (int dx = -1; dx <= 1; dx++) begin
            xx = x + dx;
            yy = y + dy;
            wt = (dx == 0 ? 2 : 1) * (dy == 0 ? 2 : 1);
            if (xx < 0 || xx > w || yy < 0 || yy > h) begin
               if (!e) continue;
               xx = xx < 0 ? 0 : xx > w ? w : xx;
               yy = yy < 0 ? 0 : yy > h ? h : yy;
            end
            p = img[yy*(w+1)+xx];
            sum += wt * int'(p[c*8 +: 8]);
         end
      l = (sum + 8) / 16;
      return 8'(l);
   endfunction

   task automatic do_reset(input int w, input int h, input bit e, input bit b, input bit s);
      @(negedge clk);
      rst = 1; px_in_valid = 0; px_out_ready = 0;
      cfg_width = 10'(w); cfg_height = 10'(h); cfg_edge = e; cfg_bypass = b;
`ifdef LPF3X3_MC_SHARPEN_EN
      cfg_sharpen = s;
`else
      if (s) $display("sharpen ignored in this build");
`endif
      repeat (2) @(negedge clk);
      chk("rst in_ready", 32'(px_in_ready), 0);
      chk("rst out_valid", 32'(px_out_valid), 0);
      chk("rst last_x", 32'(px_out_last_x), 0);
      chk("rst last_y", 32'(px_out_last_y), 0);
      chk("rst data", 32'(px_out_data), 0);
      chk("rst done", 32'(done), 0);
      repeat (8) @(negedge clk);
      rst = 0;
   endtask

   task automatic run_frame(input int w, input int h, input int pct, input string nm);
      int n, ii, oi, cyc, extra;
      logic [23:0] prev;
      logic hold;
      n = (w+1)*(h+1); ii = 0; oi = 0; cyc = 0; extra = 0; prev = 0; hold = 0;
      while (oi < n && cyc < 4000) begin
         @(negedge clk);
         px_in_valid  = ii < n && $urandom_range(99) >= pct;
         px_in_data   = px_in_valid ? img[ii] : 24'($urandom);
         px_out_ready = $urandom_range(99) >= pct;
         #1;
         if (hold) chk({nm, " stall"}, 32'(px_out_data), 32'(prev));
         hold = px_out_valid && !px_out_ready;
         prev = px_out_data;
         if (px_in_valid && px_in_ready) ii++;
         if (px_out_valid && px_out_ready) begin
            chk($sformatf("%s data[%0d]", nm, oi), 32'(px_out_data), 32'(exp_a[oi]));
            chk($sformatf("%s last_x[%0d]", nm, oi), 32'(px_out_last_x), 32'((oi % (w+1)) == w));
            chk($sformatf("%s last_y[%0d]", nm, oi), 32'(px_out_last_y), 32'((oi / (w+1)) == h));
            chk($sformatf("%s done_early[%0d]", nm, oi), 32'(done), 0);
            oi++;
         end
         cyc++;
      end
      chk({nm, " out_count"}, 32'(oi), 32'(n));
      @(negedge clk);
      px_in_valid = 1; px_out_ready = 1;
      #1;
      chk({nm, " done"}, 32'(done), 1);
      chk({nm, " in_ready_done"}, 32'(px_in_ready), 0);
      repeat (16) begin
         @(negedge clk);
         #1;
         if (px_out_valid) extra++;
      end
      chk({nm, " extra_outputs"}, 32'(extra), 0);
      px_in_valid = 0;
   endtask

   initial begin
      int nx, ny, ev, k, c;
      logic [7:0] v8;
      tv[0] = '{3, 2, 1'b0, 1'b0, 16, 16, 12, 12, 9, 0};
      tv[1] = '{3, 2, 1'b1, 1'b0, 16, 16, 16, 16, 16, 0};
      tv[2] = '{0, 0, 1'b0, 1'b0, 255, 0, 0, 0, 0, 64};
      tv[3] = '{0, 0, 1'b1, 1'b0, 255, 0, 0, 0, 0, 255};
      tv[4] = '{0, 0, 1'b0, 1'b1, 255, 0, 0, 0, 0, 255};
      for (int t = 0; t < 5; t++) begin
         v8 = 8'(tv[t].v);
         for (int y = 0; y <= tv[t].h; y++)
            for (int x = 0; x <= tv[t].w; x++) begin
               nx = (x == 0 ? 1 : 0) + (x == tv[t].w ? 1 : 0);
               ny = (y == 0 ? 1 : 0) + (y == tv[t].h ? 1 : 0);
               ev = (nx == 2 && ny == 2) ? tv[t].e_p : (nx == 0 && ny == 0) ? tv[t].e_mid :
                    (ny == 0) ? tv[t].e_x : (nx == 0) ? tv[t].e_y : tv[t].e_c;
               img[y*(tv[t].w+1)+x]   = {3{v8}};
               exp_a[y*(tv[t].w+1)+x] = {3{8'(ev)}};
            end
         do_reset(tv[t].w, tv[t].h, tv[t].e, tv[t].b, 1'b0);
         run_frame(tv[t].w, tv[t].h, 0, $sformatf("vec%0d", t));
      end
      // random 8x5 frames with stalls: zero-pad, replicate, bypass
      for (int m = 0; m < 3; m++) begin
         for (int i = 0; i < 40; i++) img[i] = 24'($urandom);
         for (int y = 0; y <= 4; y++)
            for (int x = 0; x <= 7; x++)
               exp_a[y*8+x] = m == 2 ? img[y*8+x] :
                  {gold(x, y, 2, 7, 4, m == 1), gold(x, y, 1, 7, 4, m == 1), gold(x, y, 0, 7, 4, m == 1)};
         do_reset(7, 4, m == 1, m == 2, 1'b0);
         run_frame(7, 4, 50, $sformatf("rand%0d", m));
      end
      // abort a 4x3 frame after 10 inputs, then a clean 2x2 frame
      do_reset(3, 2, 1'b0, 1'b0, 1'b0);
      k = 0; c = 0;
      while (k < 10 && c < 100) begin
         @(negedge clk);
         px_in_valid = 1; px_in_data = 24'hC8C8C8; px_out_ready = 1;
         #1;
         if (px_in_valid && px_in_ready) k++;
         c++;
      end
      chk("abort feed", 32'(k), 10);
      for (int i = 0; i < 4; i++) begin
         img[i] = 24'h202020;
         exp_a[i] = 24'h121212;
      end
      do_reset(1, 1, 1'b0, 1'b0, 1'b0);
      run_frame(1, 1, 0, "after_abort");
`ifdef LPF3X3_MC_SHARPEN_EN
      for (int i = 0; i < 9; i++) begin
         img[i] = i == 4 ? 24'hC8C8C8 : 24'h0;
         exp_a[i] = i == 4 ? 24'hFFFFFF : 24'h0;
      end
      do_reset(2, 2, 1'b1, 1'b0, 1'b1);
      run_frame(2, 2, 0, "sharpen");
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
